// File: rtl/fifo_write_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fifo_write_arbiter_if : requester/FIFO-side bundle for the write arbiter |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface fifo_write_arbiter_if #(
  parameter int Data_Width = 16,
  parameter int N_Req      = 4
);
  localparam int c_id_w = (N_Req > 1) ? $clog2(N_Req) : 1;

  logic [N_Req-1:0]            req;
  logic [N_Req*Data_Width-1:0] req_data;
  logic                        full_i;
  logic [N_Req-1:0]            gnt;
  logic                        w;
  logic [Data_Width-1:0]       data_in;
  logic                        busy;
  logic [c_id_w-1:0]           active_id;

  // master: requesters plus the FIFO full flag; slave: the arbiter
  modport master (
    output req, req_data, full_i,
    input  gnt, w, data_in, busy, active_id
  );

  modport slave (
    input  req, req_data, full_i,
    output gnt, w, data_in, busy, active_id
  );
endinterface
`default_nettype wire

// File: rtl/fifo_write_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fifo_write_arbiter : round-robin arbiter sharing one FIFO write port      |
// | Optional burst lock enabled by defining FIFO_ARB_BURST_EN.               |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module fifo_write_arbiter #(
  parameter int Data_Width = 16,
  parameter int N_Req      = 4,
  parameter int Burst_Len  = 4
) (
  input  wire logic              clk,
  input  wire logic              reset,
  fifo_write_arbiter_if.slave    bus
);
  localparam int                c_id_w = (N_Req > 1) ? $clog2(N_Req) : 1;
  localparam logic [c_id_w-1:0] c_last = c_id_w'(N_Req - 1);

  if (N_Req < 2 || Burst_Len < 1) begin : g_param_check
    $error("fifo_write_arbiter: N_Req must be >= 2 and Burst_Len >= 1");
  end

  logic [c_id_w-1:0]     r_ptr;
  logic [c_id_w-1:0]     w_ptr_next;
  logic [c_id_w-1:0]     r_active;
  logic [c_id_w-1:0]     w_active_next;
  logic                  w_found;
  logic [c_id_w-1:0]     w_found_idx;
  logic                  w_grant;
  logic [c_id_w-1:0]     w_grant_idx;
  logic [N_Req-1:0]      w_gnt;
  logic [Data_Width-1:0] w_data;

  // Modulo-N_Req increment; explicit wrap keeps non-power-of-2 counts in range
  function automatic logic [c_id_w-1:0] f_inc(input logic [c_id_w-1:0] v);
    return (v == c_last) ? '0 : v + 1'b1;
  endfunction

  // First requesting index at or after r_ptr, scanning upward with wrap
  always_comb begin
    logic [c_id_w-1:0] v_idx;
    w_found     = 1'b0;
    w_found_idx = '0;
    v_idx       = r_ptr;
    for (int i = 0; i < N_Req; i++) begin
      if (!w_found && bus.req[v_idx]) begin
        w_found     = 1'b1;
        w_found_idx = v_idx;
      end
      v_idx = f_inc(v_idx);
    end
  end

`ifdef FIFO_ARB_BURST_EN
  localparam int                 c_cnt_w = $clog2(Burst_Len + 1);
  localparam logic [c_cnt_w-1:0] c_burst = c_cnt_w'(Burst_Len);
  localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [c_cnt_w-1:0]   w_cnt_next;
  logic [c_cnt_w-1:0]   w_cnt_inc;
  logic [c_id_w-1:0]    r_owner;
  logic [c_id_w-1:0]    w_owner_next;
  logic                 r_busy;

  assign w_cnt_inc = r_cnt + 1'b1;

  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_owner_next  = r_owner;
    w_ptr_next    = r_ptr;
    w_active_next = r_active;
    w_grant       = 1'b0;
    w_grant_idx   = '0;
    // full_i freezes everything, including a held lock and its beat count
    if (!reset && !bus.full_i) begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            w_grant       = 1'b1;
            w_grant_idx   = w_found_idx;
            w_active_next = w_found_idx;
            w_ptr_next    = f_inc(w_found_idx);
            if (Burst_Len > 1) begin
              w_state_next = LOCK;
              w_owner_next = w_found_idx;
              w_cnt_next   = c_one;
            end
          end
        end
        LOCK: begin
          if (bus.req[r_owner]) begin
            w_grant       = 1'b1;
            w_grant_idx   = r_owner;
            w_active_next = r_owner;
            w_cnt_next    = w_cnt_inc;
            if (w_cnt_inc == c_burst) begin
              w_state_next = IDLE;
              w_cnt_next   = '0;
              w_ptr_next   = f_inc(r_owner);
            end
          end else begin
            // owner went away: bubble cycle, release the port
            w_state_next = IDLE;
            w_cnt_next   = '0;
            w_ptr_next   = f_inc(r_owner);
          end
        end
        default: begin
          w_state_next = IDLE;
          w_cnt_next   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_owner <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_owner <= w_owner_next;
      r_busy  <= (w_state_next == LOCK);
    end
  end

  assign bus.busy = r_busy;
`else
  always_comb begin
    w_ptr_next    = r_ptr;
    w_active_next = r_active;
    w_grant       = 1'b0;
    w_grant_idx   = '0;
    if (!reset && !bus.full_i && w_found) begin
      w_grant       = 1'b1;
      w_grant_idx   = w_found_idx;
      w_active_next = w_found_idx;
      w_ptr_next    = f_inc(w_found_idx);
    end
  end

  assign bus.busy = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr    <= '0;
      r_active <= '0;
    end else begin
      r_ptr    <= w_ptr_next;
      r_active <= w_active_next;
    end
  end

  always_comb begin
    w_gnt  = '0;
    w_data = '0;
    if (w_grant) begin
      w_gnt[w_grant_idx] = 1'b1;
      w_data             = bus.req_data[w_grant_idx*Data_Width +: Data_Width];
    end
  end

  assign bus.gnt       = w_gnt;
  assign bus.w         = w_grant;
  assign bus.data_in   = w_data;
  assign bus.active_id = r_active;
endmodule
`default_nettype wire
